// File: rtl/banco_registros_param.sv
// banco_registros_param
// Parametrised integer register file for the decode/writeback stages.
// Index 0 is hardwired to zero and has no storage. Each register carries a
// busy bit marking a pending writeback, and a bulk-clear engine sweeps all
// registers back to zero one index per clock while Ready is low.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RESET_N     asynchronous active-low reset
//   readReg     NREAD packed read indices, port p at [p*AW +: AW]
//   readData    NREAD packed read data, port p at [p*XLEN +: XLEN]
//   readBusy    per-port busy flag of the addressed register
//   RegWrite    write enable
//   writeReg    write index
//   writeData   write data
//   Reserve     mark reserveReg busy
//   reserveReg  index to reserve
//   Clear       start a bulk clear, sampled only while Ready is high
//   Ready       1 when idle, 0 while the clear sweep runs
module banco_registros_param #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [NREAD*AW-1:0]   readReg,
    output logic [NREAD*XLEN-1:0] readData,
    output logic [NREAD-1:0]      readBusy,
    input  logic                  RegWrite,
    input  logic [AW-1:0]         writeReg,
    input  logic [XLEN-1:0]       writeData,
    input  logic                  Reserve,
    input  logic [AW-1:0]         reserveReg,
    input  logic                  Clear,
    output logic                  Ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsmState_t;

    fsmState_t state;
    fsmState_t nextState;
    logic [AW-1:0] idx;
    logic [AW-1:0] nextIdx;

    logic [XLEN-1:0] regs [1:NREGS-1];
    logic [NREGS-1:1] busyBits;

    // State register for the clear sequencer and its sweep pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
        end
    end

    // Next-state logic. The sweep starts at index 1 (index 0 has no
    // storage) and returns to IDLE on the edge that clears the last entry,
    // so a sweep is exactly NREGS-1 edges long.
    always_comb begin
        nextState = state;
        nextIdx   = idx;
        case (state)
            IDLE: begin
                if (Clear) begin
                    nextState = CLEAR;
                    nextIdx   = AW'(1);
                end
            end
            CLEAR: begin
                nextIdx = idx + AW'(1);
                if (idx == AW'(NREGS - 1)) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
                nextIdx   = '0;
            end
        endcase
    end

    // Storage and scoreboard. During a sweep only the entry under idx is
    // touched; writes and reservations are ignored. In IDLE a Clear on the
    // same edge drops any write or reserve. A reserve is applied after the
    // write so that reserve wins when both target the same index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int r = 1; r < NREGS; r++) begin
                regs[r]     <= '0;
                busyBits[r] <= 1'b0;
            end
        end else if (state == CLEAR) begin
            for (int r = 1; r < NREGS; r++) begin
                if (idx == AW'(r)) begin
                    regs[r]     <= '0;
                    busyBits[r] <= 1'b0;
                end
            end
        end else if (!Clear) begin
            for (int r = 1; r < NREGS; r++) begin
                if (RegWrite && (writeReg == AW'(r))) begin
                    regs[r]     <= writeData;
                    busyBits[r] <= 1'b0;
                end
                if (Reserve && (reserveReg == AW'(r))) begin
                    busyBits[r] <= 1'b1;
                end
            end
        end
    end

    // Combinational read ports. Index 0 falls through the lookup and keeps
    // the zero default. The bypass deliberately ignores Clear so that no
    // output depends combinationally on Clear.
    always_comb begin
        readData = '0;
        readBusy = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (readReg[p*AW +: AW] == AW'(r)) begin
                    readData[p*XLEN +: XLEN] = regs[r];
                    readBusy[p]              = busyBits[r];
                end
            end
            if ((BYPASS == 1) && (state == IDLE) && RegWrite &&
                (writeReg != '0) && (writeReg == readReg[p*AW +: AW])) begin
                readData[p*XLEN +: XLEN] = writeData;
                readBusy[p]              = 1'b0;
            end
        end
    end

    assign Ready = (state == IDLE);

endmodule

// File: tb/tb_banco_registros_param.sv
// Testbench for banco_registros_param. Two instances share every input:
// one built with the write bypass, one without. A reference model holds the
// architectural registers, busy flags and the number of sweep edges still
// outstanding, and predicts every read port and Ready.
module tb_banco_registros_param;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  CLK;
    logic                  RESET_N;
    logic [NREAD*AW-1:0]   readReg;
    logic [NREAD*XLEN-1:0] readDataB;
    logic [NREAD-1:0]      readBusyB;
    logic                  readyB;
    logic [NREAD*XLEN-1:0] readDataN;
    logic [NREAD-1:0]      readBusyN;
    logic                  readyN;
    logic                  RegWrite;
    logic [AW-1:0]         writeReg;
    logic [XLEN-1:0]       writeData;
    logic                  Reserve;
    logic [AW-1:0]         reserveReg;
    logic                  Clear;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] mReg [NREGS];
    bit              mBusy [NREGS];
    int              mSweepLeft;

    banco_registros_param #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)
    ) dutBypass (
        .CLK(CLK), .RESET_N(RESET_N),
        .readReg(readReg), .readData(readDataB), .readBusy(readBusyB),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .Reserve(Reserve), .reserveReg(reserveReg),
        .Clear(Clear), .Ready(readyB)
    );

    banco_registros_param #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)
    ) dutNoBypass (
        .CLK(CLK), .RESET_N(RESET_N),
        .readReg(readReg), .readData(readDataN), .readBusy(readBusyN),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .Reserve(Reserve), .reserveReg(reserveReg),
        .Clear(Clear), .Ready(readyN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model reset: everything architectural goes back to zero.
    task automatic modelReset();
        for (int r = 0; r < NREGS; r++) begin
            mReg[r]  = '0;
            mBusy[r] = 1'b0;
        end
        mSweepLeft = 0;
    endtask

    // Model of one rising edge from the architectural rules.
    task automatic modelEdge();
        if (!RESET_N) begin
            modelReset();
        end else if (mSweepLeft > 0) begin
            mReg[NREGS - mSweepLeft]  = '0;
            mBusy[NREGS - mSweepLeft] = 1'b0;
            mSweepLeft--;
        end else if (Clear) begin
            mSweepLeft = NREGS - 1;
        end else begin
            if (RegWrite && writeReg != 0) begin
                mReg[writeReg]  = writeData;
                mBusy[writeReg] = 1'b0;
            end
            if (Reserve && reserveReg != 0) begin
                mBusy[reserveReg] = 1'b1;
            end
        end
    endtask

    // Expected {busy, data} for one read index.
    function automatic logic [XLEN:0] modelRead(logic [AW-1:0] a, bit byp);
        if (a == 0) return '0;
        if (byp && RESET_N && mSweepLeft == 0 && RegWrite && writeReg == a)
            return {1'b0, writeData};
        return {mBusy[a], mReg[a]};
    endfunction

    task automatic checkOutput(string tag, logic [XLEN-1:0] observed,
                               logic [XLEN-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h @%0t",
                   tag, observed, expected, $time);
        end
    endtask

    // Compares every output of both instances with the model.
    task automatic checkAll(string tag);
        logic [XLEN:0] e;
        for (int p = 0; p < NREAD; p++) begin
            e = modelRead(readReg[p*AW +: AW], 1'b1);
            checkOutput($sformatf("%s.byp.data%0d", tag, p),
                        readDataB[p*XLEN +: XLEN], e[XLEN-1:0]);
            checkOutput($sformatf("%s.byp.busy%0d", tag, p),
                        XLEN'(readBusyB[p]), XLEN'(e[XLEN]));
            e = modelRead(readReg[p*AW +: AW], 1'b0);
            checkOutput($sformatf("%s.nob.data%0d", tag, p),
                        readDataN[p*XLEN +: XLEN], e[XLEN-1:0]);
            checkOutput($sformatf("%s.nob.busy%0d", tag, p),
                        XLEN'(readBusyN[p]), XLEN'(e[XLEN]));
        end
        checkOutput({tag, ".byp.ready"}, XLEN'(readyB), XLEN'(mSweepLeft == 0));
        checkOutput({tag, ".nob.ready"}, XLEN'(readyN), XLEN'(mSweepLeft == 0));
    endtask

    // One cycle: inputs already set after a falling edge; check, clock,
    // update the model and come back to the falling edge.
    task automatic applyStimulus(string tag);
        #1;
        checkAll(tag);
        @(posedge CLK);
        modelEdge();
        @(negedge CLK);
    endtask

    task automatic idleInputs();
        RegWrite   = 1'b0;
        writeReg   = '0;
        writeData  = '0;
        Reserve    = 1'b0;
        reserveReg = '0;
        Clear      = 1'b0;
    endtask

    // Walks every index through both read ports over 16 cycles.
    task automatic readAll(string tag);
        for (int a = 0; a < NREGS; a += 2) begin
            readReg = {AW'(a + 1), AW'(a)};
            applyStimulus(tag);
        end
    endtask

    task automatic fillRegisters();
        for (int r = 1; r < NREGS; r++) begin
            RegWrite  = 1'b1;
            writeReg  = AW'(r);
            writeData = $urandom | 32'h1;
            readReg   = AW*NREAD'($urandom);
            applyStimulus("fill");
        end
        idleInputs();
    endtask

    // Counts cycles with Ready low after a Clear edge, bounded.
    task automatic measureSweep(string tag, output int lowCycles);
        lowCycles = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (readyB) break;
            lowCycles++;
            readReg = AW*NREAD'($urandom);
            if (c == 15) begin
                RegWrite   = 1'b1;
                writeReg   = AW'(2);
                writeData  = 32'h5555_AAAA;
                Reserve    = 1'b1;
                reserveReg = AW'(3);
            end else begin
                idleInputs();
            end
            applyStimulus(tag);
        end
        idleInputs();
    endtask

    initial begin
        int lowCycles;
        modelReset();
        idleInputs();
        readReg = '0;
        RESET_N = 1'b1;

        // Reset asserted mid-cycle.
        #2;
        RESET_N = 1'b0;
        #1;
        checkAll("reset.now");
        @(negedge CLK);
        readAll("reset.hold");
        RESET_N = 1'b1;
        readAll("reset.after");

        // Write and readback with the bypass.
        RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
        readReg = {5'd0, 5'd5};
        applyStimulus("wr.x5");
        idleInputs();
        applyStimulus("rd.x5.1");
        applyStimulus("rd.x5.2");
        RegWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
        readReg = {5'd5, 5'd0};
        applyStimulus("wr.x0");
        idleInputs();
        applyStimulus("rd.x0");

        // Scoreboard.
        Reserve = 1'b1; reserveReg = 5'd7;
        applyStimulus("rsv.x7");
        idleInputs();
        readReg = {5'd7, 5'd5};
        applyStimulus("busy.x7");
        RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'h42;
        applyStimulus("wr.x7");
        idleInputs();
        applyStimulus("rd.x7");
        RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'h9999;
        Reserve = 1'b1; reserveReg = 5'd9;
        readReg = {5'd9, 5'd9};
        applyStimulus("wrsv.x9");
        idleInputs();
        applyStimulus("rd.x9");

        // Same-cycle write visibility with and without the bypass.
        RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5;
        readReg = {5'd3, 5'd3};
        applyStimulus("wr.x3");
        idleInputs();
        applyStimulus("rd.x3");

        // Random traffic including occasional sweeps.
        for (int i = 0; i < 300; i++) begin
            RegWrite   = 1'($urandom);
            writeReg   = AW'($urandom);
            writeData  = $urandom;
            Reserve    = ($urandom_range(0, 3) == 0);
            reserveReg = AW'($urandom);
            Clear      = ($urandom_range(0, 59) == 0);
            readReg    = AW*NREAD'($urandom);
            if ($urandom_range(0, 3) == 0) readReg[AW-1:0] = writeReg;
            applyStimulus("rand");
        end
        idleInputs();
        for (int i = 0; i < 40 && mSweepLeft != 0; i++) applyStimulus("drain");

        // Full clear sweep with a write and reserve issued mid-sweep.
        fillRegisters();
        Reserve = 1'b1; reserveReg = 5'd12;
        applyStimulus("rsv.x12");
        Clear = 1'b1;
        applyStimulus("clear.start");
        idleInputs();
        measureSweep("sweep", lowCycles);
        checkOutput("sweep.lowCycles", XLEN'(lowCycles), XLEN'(NREGS - 1));
        readAll("sweep.after");

        // Reset during the sweep, then a fresh complete sweep.
        fillRegisters();
        Clear = 1'b1;
        applyStimulus("clear2.start");
        idleInputs();
        for (int c = 0; c < 10; c++) begin
            readReg = AW*NREAD'($urandom);
            applyStimulus("sweep2");
        end
        #2;
        RESET_N = 1'b0;
        modelReset();
        #1;
        checkAll("abort.now");
        checkOutput("abort.ready", XLEN'(readyB), XLEN'(1));
        readAll("abort.hold");
        RESET_N = 1'b1;
        fillRegisters();
        Clear = 1'b1;
        applyStimulus("clear3.start");
        idleInputs();
        measureSweep("sweep3", lowCycles);
        checkOutput("sweep3.lowCycles", XLEN'(lowCycles), XLEN'(NREGS - 1));
        readAll("sweep3.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
